// File: rtl/phys_reg_freelist_if.sv
// ============================================================================
// Module   : phys_reg_freelist_if
// Purpose  : Rename/commit bus of the physical register free list.
//            Optional macro PHYS_REG_FREELIST_RECOVERY_EN adds flush/commit_alloc_num.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface phys_reg_freelist_if #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int PHYS_REGS_ADDR_WIDTH = 7
);
  localparam int c_DW_AW = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [DISPATCH_WIDTH-1:0]                           alloc_req;
  logic                                                alloc_ready;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] alloc_preg;
  logic [DISPATCH_WIDTH-1:0]                           free_valid;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_preg;
  logic [PHYS_REGS_ADDR_WIDTH:0]                       free_count;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
  logic                                                flush;
  logic [c_DW_AW:0]                                    commit_alloc_num;

  modport master (
    output alloc_req, free_valid, free_preg, flush, commit_alloc_num,
    input  alloc_ready, alloc_preg, free_count
  );
  modport slave (
    input  alloc_req, free_valid, free_preg, flush, commit_alloc_num,
    output alloc_ready, alloc_preg, free_count
  );
`else
  modport master (
    output alloc_req, free_valid, free_preg,
    input  alloc_ready, alloc_preg, free_count
  );
  modport slave (
    input  alloc_req, free_valid, free_preg,
    output alloc_ready, alloc_preg, free_count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/phys_reg_freelist.sv
// ============================================================================
// Module   : phys_reg_freelist
// Purpose  : Circular free list of physical register tags for rename/commit.
//            Optional macro PHYS_REG_FREELIST_RECOVERY_EN adds flush recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phys_reg_freelist #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int PHYS_REGS            = 128,
  parameter int PHYS_REGS_ADDR_WIDTH = 7,
  parameter int ARCH_REGS            = 32
) (
  input  logic                clk,
  input  logic                rst,
  phys_reg_freelist_if.slave  fl
);
  localparam int c_AW        = PHYS_REGS_ADDR_WIDTH;
  localparam int c_CW        = PHYS_REGS_ADDR_WIDTH + 1;
  localparam int c_FREE_INIT = PHYS_REGS - ARCH_REGS;

  logic [c_AW-1:0]                     r_list [PHYS_REGS];
  logic [c_AW-1:0]                     r_head;
  logic [c_AW-1:0]                     r_tail;
  logic [c_CW-1:0]                     r_count;

  logic [DISPATCH_WIDTH-1:0][c_AW-1:0] w_alloc_preg;
  logic [DISPATCH_WIDTH-1:0][c_AW-1:0] w_free_slot;
  logic [c_CW-1:0]                     w_req_cnt;
  logic [c_CW-1:0]                     w_free_cnt;
  logic [c_CW-1:0]                     w_nalloc;
  logic [c_CW-1:0]                     w_count_next;
  logic [c_AW-1:0]                     w_head_next;
  logic [c_AW-1:0]                     w_tail_next;
  logic                                w_ready;
  logic                                w_take;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
  logic [c_AW-1:0]                     r_commit_head;
  logic [c_AW-1:0]                     w_commit_head_next;
`endif

  // Readiness uses registered count only; frees this cycle give no credit.
  assign w_ready = (r_count >= c_CW'(DISPATCH_WIDTH));

  always_comb begin : p_alloc
    w_alloc_preg = '0;
    w_req_cnt    = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (fl.alloc_req[l]) begin
        w_alloc_preg[l] = r_list[r_head + c_AW'(w_req_cnt)];
        w_req_cnt       = w_req_cnt + c_CW'(1);
      end
    end
  end

  always_comb begin : p_free
    w_free_slot = '0;
    w_free_cnt  = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      w_free_slot[l] = r_tail + c_AW'(w_free_cnt);
      if (fl.free_valid[l]) begin
        w_free_cnt = w_free_cnt + c_CW'(1);
      end
    end
  end

  always_comb begin : p_next
    w_take = w_ready;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
    if (fl.flush) begin
      w_take = 1'b0;
    end
`endif
    w_nalloc     = w_take ? w_req_cnt : '0;
    w_head_next  = r_head + c_AW'(w_nalloc);
    w_tail_next  = r_tail + c_AW'(w_free_cnt);
    w_count_next = r_count + w_free_cnt - w_nalloc;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
    w_commit_head_next = r_commit_head + c_AW'(fl.commit_alloc_num);
    // Flush rewinds the pop pointer to the committed point; count is re-derived.
    if (fl.flush) begin
      w_head_next  = w_commit_head_next;
      w_count_next = {1'b0, w_tail_next - w_head_next};
    end
`endif
  end

  assign fl.alloc_ready = w_ready;
  assign fl.alloc_preg  = w_alloc_preg;
  assign fl.free_count  = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_list[i] <= (i < c_FREE_INIT) ? c_AW'(i + ARCH_REGS) : '0;
      end
      r_head  <= '0;
      r_tail  <= c_AW'(c_FREE_INIT);
      r_count <= c_CW'(c_FREE_INIT);
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
      r_commit_head <= '0;
`endif
    end else begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (fl.free_valid[l]) begin
          r_list[w_free_slot[l]] <= fl.free_preg[l];
        end
      end
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
      r_commit_head <= w_commit_head_next;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_phys_reg_freelist.sv
// ============================================================================
// Module   : tb_phys_reg_freelist
// Purpose  : Scoreboard bench for phys_reg_freelist (FIFO reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phys_reg_freelist;

  typedef struct {
    logic            ready;
    logic [7:0]      count;
    logic [1:0]      req;
    logic            grant;
    logic [1:0][6:0] tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  exp_t       expq [$];
  exp_t       mon_e;
  logic [6:0] mdl  [$];
  logic [6:0] outst[$];

  phys_reg_freelist_if bus ();

  phys_reg_freelist u_dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      n_checks++;
      if (bus.alloc_ready !== mon_e.ready) begin
        n_errors++;
        $display("FAIL mon_ready: got %0b expected %0b", bus.alloc_ready, mon_e.ready);
      end
      n_checks++;
      if (bus.free_count !== mon_e.count) begin
        n_errors++;
        $display("FAIL mon_count: got %0d expected %0d", bus.free_count, mon_e.count);
      end
      if (mon_e.grant) begin
        for (int l = 0; l < 2; l++) begin
          n_checks++;
          if (bus.alloc_preg[l] !== mon_e.tag[l]) begin
            n_errors++;
            $display("FAIL mon_grant lane%0d (req=%b): got %0d expected %0d",
                     l, mon_e.req, bus.alloc_preg[l], mon_e.tag[l]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alloc_req  = '0;
    bus.free_valid = '0;
    bus.free_preg  = '0;
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
    bus.flush            = 1'b0;
    bus.commit_alloc_num = '0;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl.delete();
    outst.delete();
    for (int i = 32; i < 128; i++) mdl.push_back(7'(i));
  endtask

  // One cycle: model predicts, expectation queued, DUT driven.
  task automatic step(input logic [1:0] req, input logic [1:0] fv,
                      input logic [6:0] f0, input logic [6:0] f1,
                      input logic flush, input logic [1:0] cnum);
    exp_t e;
    e.ready = (mdl.size() >= 2);
    e.count = 8'(mdl.size());
    e.req   = req;
    e.grant = e.ready && !flush;
    e.tag   = '0;
    if (e.grant) begin
      for (int l = 0; l < 2; l++) begin
        if (req[l]) begin
          e.tag[l] = mdl.pop_front();
          outst.push_back(e.tag[l]);
        end
      end
    end
    if (fv[0]) mdl.push_back(f0);
    if (fv[1]) mdl.push_back(f1);
    for (int k = 0; k < int'(cnum); k++) void'(outst.pop_front());
    if (flush) begin
      for (int i = outst.size() - 1; i >= 0; i--) mdl.push_front(outst[i]);
      outst.delete();
    end
    expq.push_back(e);
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_preg  = {f1, f0};
`ifdef PHYS_REG_FREELIST_RECOVERY_EN
    bus.flush            = flush;
    bus.commit_alloc_num = cnum;
`endif
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  logic [1:0] rq, fv;
  logic [6:0] f0, f1;
  int         idx;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    drive_idle();

    // Reset image
    do_reset();
    check("rst_count", 32'(bus.free_count), 32'd96);
    check("rst_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_idle_preg", 32'(bus.alloc_preg), 32'd0);

    // Full group after reset: {33,32}
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t1_count", 32'(bus.free_count), 32'd94);

    // Lane1 only: lane1=32, lane0=0; then lane0 gets 33
    do_reset();
    step(2'b10, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t2_count", 32'(bus.free_count), 32'd95);
    step(2'b01, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);

    // Drain to empty, then free {5,7}
    do_reset();
    repeat (48) step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t3_empty_count", 32'(bus.free_count), 32'd0);
    check("t3_empty_ready", 32'(bus.alloc_ready), 32'd0);
    step(2'b11, 2'b11, 7'd5, 7'd7, 1'b0, 2'd0);
    check("t3_refill_count", 32'(bus.free_count), 32'd2);
    check("t3_refill_ready", 32'(bus.alloc_ready), 32'd1);
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t3_after_count", 32'(bus.free_count), 32'd0);

    // Same-cycle alloc and free at count 10
    do_reset();
    repeat (43) step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t4_pre_count", 32'(bus.free_count), 32'd10);
    step(2'b11, 2'b11, 7'd40, 7'd41, 1'b0, 2'd0);
    check("t4_post_count", 32'(bus.free_count), 32'd10);
    repeat (6) step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);

    // Reset in the middle of operation
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    do_reset();
    check("midrst_count", 32'(bus.free_count), 32'd96);
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);

    // Wrap: random traffic recycling outstanding tags
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rq = 2'($urandom_range(0, 3));
      fv = 2'b00;
      f0 = '0;
      f1 = '0;
      if (outst.size() > 0 && $urandom_range(0, 3) != 0) begin
        idx = int'($urandom_range(0, outst.size() - 1));
        f0 = outst[idx];
        outst.delete(idx);
        fv[0] = 1'b1;
      end
      if (outst.size() > 0 && $urandom_range(0, 1) != 0) begin
        idx = int'($urandom_range(0, outst.size() - 1));
        f1 = outst[idx];
        outst.delete(idx);
        fv[1] = 1'b1;
      end
      step(rq, fv, f0, f1, 1'b0, 2'd0);
    end
    check("t5_count_model", 32'(bus.free_count), 32'(mdl.size()));

`ifdef PHYS_REG_FREELIST_RECOVERY_EN
    // Recovery: 6 allocated, 2 committed, flush -> head 2, next {35,34}
    do_reset();
    repeat (3) step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b1, 2'd2);
    check("t6_flush_count", 32'(bus.free_count), 32'd94);
    step(2'b11, 2'b00, 7'd0, 7'd0, 1'b0, 2'd0);
    check("t6_post_count", 32'(bus.free_count), 32'd92);
`endif

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
